// File: rtl/router_rr_scheduler.sv
// Round-robin front end for the 4-port router: picks one requester per cycle,
// optionally holds the grant for a burst, and registers the beat onto din/addr.
module router_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]          req_addr,
  input  logic [3:0]                    dest_block,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         din,
  output logic                          din_en,
  output logic [1:0]                    addr,
  output logic                          locked,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int             IW        = $clog2(NUM_REQ);
  localparam logic [3:0]     BURST_MAX = 4'(BURST_LEN);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [3:0]      beat_cnt;
  logic [3:0]      beat_nxt;

  logic [NUM_REQ-1:0] eligible;
  logic               owner_ok;
  logic               grant_any;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      scan_start;
  logic [IW-1:0]      cand;

  // Modulo increment; NUM_REQ need not be a power of two.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    eligible   = '0;
    grant_any  = 1'b0;
    grant_idx  = owner;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && !dest_block[req_addr[i*2 +: 2]];

    owner_ok   = (state == LOCK) && eligible[owner];
    scan_start = (state == LOCK) ? next_idx(owner) : rr_ptr;

    if (owner_ok) begin
      grant_any = 1'b1;
    end else begin
      // A released owner hands over in the same cycle, scanning from owner+1.
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = IW'((int'(scan_start) + k) % NUM_REQ);
        if (!grant_any && eligible[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end

    req_ready = '0;
    if (grant_any && resetn)
      req_ready[grant_idx] = 1'b1;
  end

  assign beat_nxt = beat_cnt + 4'd1;
  assign locked   = (state == LOCK);

  // NOTE: sequential state uses non-blocking assignments only; later writes in the same block win.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      din      <= '0;
      din_en   <= 1'b0;
      addr     <= '0;
    end else begin
      din_en <= grant_any;
      din    <= grant_any ? req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
      addr   <= grant_any ? req_addr[int'(grant_idx)*2 +: 2] : 2'd0;

      if (owner_ok) begin
        beat_cnt <= beat_nxt;
        if (beat_nxt >= BURST_MAX) begin
          rr_ptr <= next_idx(owner);
          state  <= IDLE;
        end
      end else begin
        if (state == LOCK)
          rr_ptr <= next_idx(owner);
        if (grant_any) begin
          owner    <= grant_idx;
          beat_cnt <= 4'd1;
          if (BURST_LEN == 1) begin
            rr_ptr <= next_idx(grant_idx);
            state  <= IDLE;
          end else begin
            state  <= LOCK;
          end
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_rr_scheduler.sv
// Self-checking bench for router_rr_scheduler: one instance with bursts of 4,
// one without burst lock; expected beats are queued at grant time and popped a cycle later.
module tb_router_rr_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [3:0]  dest_block;
  logic [31:0] d [4];
  logic [1:0]  a [4];

  wire [127:0] req_data = {d[3], d[2], d[1], d[0]};
  wire [7:0]   req_addr = {a[3], a[2], a[1], a[0]};

  logic [3:0]  ready0, ready1;
  logic [31:0] din0, din1;
  logic        en0, en1;
  logic [1:0]  addr0, addr1;
  logic        locked0, locked1;
  logic [1:0]  owner0, owner1;

  typedef struct packed {
    logic        en;
    logic [31:0] data;
    logic [1:0]  addr;
  } beat_t;

  beat_t sb [$];
  beat_t e;
  int    n_checks = 0;
  int    n_fail   = 0;

  router_rr_scheduler #(.DATA_WIDTH(32), .NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_addr(req_addr), .dest_block(dest_block), .req_ready(ready0), .din(din0),
    .din_en(en0), .addr(addr0), .locked(locked0), .owner(owner0)
  );

  router_rr_scheduler #(.DATA_WIDTH(32), .NUM_REQ(4), .BURST_LEN(1)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_addr(req_addr), .dest_block(dest_block), .req_ready(ready1), .din(din1),
    .din_en(en1), .addr(addr1), .locked(locked1), .owner(owner1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] oh(input int g);
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  function automatic beat_t exp_beat(input int g);
    beat_t b;
    b = '0;
    if (g >= 0) begin
      b.en   = 1'b1;
      b.data = d[g];
      b.addr = a[g];
    end
    return b;
  endfunction

  task automatic apply_reset();
    resetn     = 1'b0;
    req_valid  = '0;
    dest_block = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    req_valid = 4'hF;
    dest_block = '0;
    for (int i = 0; i < 4; i++) begin
      d[i] = 32'hDEAD_0000 + 32'(i);
      a[i] = 2'(i);
    end
    #7;
    n_checks++; if (ready0 !== 4'b0)  begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", ready0); end
    n_checks++; if (ready1 !== 4'b0)  begin n_fail++; $display("FAIL rst_ready1: got %b expected 0000", ready1); end
    n_checks++; if (en0 !== 1'b0)     begin n_fail++; $display("FAIL rst_din_en: got %b expected 0", en0); end
    n_checks++; if (din0 !== 32'h0)   begin n_fail++; $display("FAIL rst_din: got %h expected 0", din0); end
    n_checks++; if (addr0 !== 2'd0)   begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", addr0); end
    n_checks++; if (locked0 !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", locked0); end
    n_checks++; if (owner0 !== 2'd0)  begin n_fail++; $display("FAIL rst_owner: got %0d expected 0", owner0); end
    apply_reset();
  endtask

  task automatic test_single_beat();
    int          g [3]  = '{0, -1, -1};
    logic [3:0]  v [3]  = '{4'b0001, 4'b0000, 4'b0000};
    apply_reset();
    d[0] = 32'h0000_00A5; a[0] = 2'd2;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({en0, din0, addr0} !== e) begin
          n_fail++;
          $display("FAIL single_beat c%0d: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
                   c, en0, din0, addr0, e.en, e.data, e.addr);
        end
      end
      req_valid = v[c];
      @(negedge clk);
      n_checks++;
      if (ready0 !== oh(g[c])) begin n_fail++; $display("FAIL single_ready c%0d: got %b expected %b", c, ready0, oh(g[c])); end
      sb.push_back(exp_beat(g[c]));
    end
  endtask

  task automatic test_rr_no_lock();
    int g [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = 32'h1111_0000 * 32'(i + 1);
      a[i] = 2'(3 - i);
    end
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({en1, din1, addr1} !== e) begin
          n_fail++;
          $display("FAIL rr_beat c%0d: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
                   c, en1, din1, addr1, e.en, e.data, e.addr);
        end
      end
      if (c == 6) break;
      req_valid = 4'b1111;
      @(negedge clk);
      n_checks++;
      if (ready1 !== oh(g[c])) begin n_fail++; $display("FAIL rr_ready c%0d: got %b expected %b", c, ready1, oh(g[c])); end
      sb.push_back(exp_beat(g[c]));
    end
    req_valid = '0;
  endtask

  task automatic test_burst();
    int   g  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic lk [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int   ow [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    apply_reset();
    d[0] = 32'hAAAA_0001; a[0] = 2'd0;
    d[1] = 32'hBBBB_0002; a[1] = 2'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({en0, din0, addr0} !== e) begin
          n_fail++;
          $display("FAIL burst_beat c%0d: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
                   c, en0, din0, addr0, e.en, e.data, e.addr);
        end
      end
      if (c == 9) break;
      req_valid = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (ready0 !== oh(g[c])) begin n_fail++; $display("FAIL burst_ready c%0d: got %b expected %b", c, ready0, oh(g[c])); end
      n_checks++;
      if (locked0 !== lk[c]) begin n_fail++; $display("FAIL burst_locked c%0d: got %b expected %b", c, locked0, lk[c]); end
      n_checks++;
      if (owner0 !== 2'(ow[c])) begin n_fail++; $display("FAIL burst_owner c%0d: got %0d expected %0d", c, owner0, ow[c]); end
      sb.push_back(exp_beat(g[c]));
    end
    req_valid = '0;
  endtask

  task automatic test_dest_block();
    int         g  [4] = '{1, -1, 0, -1};
    logic [3:0] v  [4] = '{4'b0011, 4'b0001, 4'b0001, 4'b0000};
    logic [3:0] db [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    apply_reset();
    d[0] = 32'h0C0C_0000; a[0] = 2'd1;
    d[1] = 32'h0D0D_1111; a[1] = 2'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({en0, din0, addr0} !== e) begin
          n_fail++;
          $display("FAIL block_beat c%0d: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
                   c, en0, din0, addr0, e.en, e.data, e.addr);
        end
      end
      if (c == 4) break;
      req_valid  = v[c];
      dest_block = db[c];
      @(negedge clk);
      n_checks++;
      if (ready0 !== oh(g[c])) begin n_fail++; $display("FAIL block_ready c%0d: got %b expected %b", c, ready0, oh(g[c])); end
      sb.push_back(exp_beat(g[c]));
    end
  endtask

  task automatic test_handover();
    int         g [5] = '{0, 0, 2, 2, -1};
    logic [3:0] v [5] = '{4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0000};
    apply_reset();
    d[0] = 32'h5000_0000; a[0] = 2'd1;
    d[2] = 32'h5000_0002; a[2] = 2'd2;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({en0, din0, addr0} !== e) begin
          n_fail++;
          $display("FAIL handover_beat c%0d: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
                   c, en0, din0, addr0, e.en, e.data, e.addr);
        end
      end
      if (c == 5) break;
      req_valid = v[c];
      @(negedge clk);
      n_checks++;
      if (ready0 !== oh(g[c])) begin n_fail++; $display("FAIL handover_ready c%0d: got %b expected %b", c, ready0, oh(g[c])); end
      if (c == 3) begin
        n_checks++;
        if (owner0 !== 2'd2) begin n_fail++; $display("FAIL handover_owner: got %0d expected 2", owner0); end
        n_checks++;
        if (locked0 !== 1'b1) begin n_fail++; $display("FAIL handover_locked: got %b expected 1", locked0); end
      end
      sb.push_back(exp_beat(g[c]));
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    d[0] = 32'h6000_0000; a[0] = 2'd3;
    d[1] = 32'h6000_0001; a[1] = 2'd2;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({en0, din0, addr0} !== e) begin
          n_fail++;
          $display("FAIL midrst_beat c%0d: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
                   c, en0, din0, addr0, e.en, e.data, e.addr);
        end
      end
      req_valid = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (ready0 !== oh(1)) begin n_fail++; $display("FAIL midrst_ready c%0d: got %b expected 0010", c, ready0); end
      sb.push_back(exp_beat(1));
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if ({en0, din0, addr0} !== e) begin
      n_fail++;
      $display("FAIL midrst_beat_last: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
               en0, din0, addr0, e.en, e.data, e.addr);
    end
    n_checks++;
    if (owner0 !== 2'd1 || locked0 !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: got owner=%0d locked=%b expected owner=1 locked=1", owner0, locked0);
    end
    #2;
    resetn    = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if ({en0, din0, addr0, locked0, owner0, ready0} !== 41'b0) begin
      n_fail++;
      $display("FAIL midrst_zero: got en=%b din=%h addr=%0d locked=%b owner=%0d ready=%b expected all zero",
               en0, din0, addr0, locked0, owner0, ready0);
    end
    @(posedge clk); #3;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready0 !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b expected 0001", ready0); end
    sb.push_back(exp_beat(0));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if ({en0, din0, addr0} !== e) begin
      n_fail++;
      $display("FAIL midrst_after_beat: got en=%b din=%h addr=%0d expected en=%b din=%h addr=%0d",
               en0, din0, addr0, e.en, e.data, e.addr);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_rr_no_lock();
    test_burst();
    test_dest_block();
    test_handover();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
